// File: rtl/fifo_mem_ctrl.sv
// FIFO pointer/flag controller for an external dual-port RAM with combinational read; pop data registered (1 cycle), full rejects push unless a pop frees a slot.
// Optional FIFO_STICKY_ERR_EN makes oOverflow/oUnderflow sticky until reset; default build pulses them for one cycle.
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                  Clock,
    input  logic                  iReset_n,
    input  logic                  iPush,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iPop,
    output logic [DATA_WIDTH-1:0] oDataOut,
    output logic                  oDataValid,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oOverflow,
    output logic                  oUnderflow,
    output logic                  oMemWriteEnable,
    output logic [ADDR_WIDTH-1:0] oMemWriteAddress,
    output logic [DATA_WIDTH-1:0] oMemDataIn,
    output logic                  oMemReadEnable,
    output logic [ADDR_WIDTH-1:0] oMemReadAddress,
    input  logic [DATA_WIDTH-1:0] iMemDataOut
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q;
    logic                    full_q, empty_q, afull_q, aempty_q;
    logic                    ovf_q, ovf_d, unf_q, unf_d;
    logic                    push_ok, pop_ok;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
    assign pop_ok  = iPop & ~empty_q;
    assign push_ok = iPush & (~full_q | pop_ok);

    assign oMemWriteEnable  = push_ok;
    assign oMemWriteAddress = wr_ptr_q;
    assign oMemDataIn       = iDataIn;
    assign oMemReadEnable   = pop_ok;
    assign oMemReadAddress  = rd_ptr_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + (push_ok ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0));
        rd_ptr_d = rd_ptr_q + (pop_ok  ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0));
        count_d  = count_q + (push_ok ? CW'(1) : CW'(0)) - (pop_ok ? CW'(1) : CW'(0));
        data_d   = pop_ok ? iMemDataOut : data_q;
`ifdef FIFO_STICKY_ERR_EN
        ovf_d    = ovf_q | (iPush & ~push_ok);
        unf_d    = unf_q | (iPop & ~pop_ok);
`else
        ovf_d    = iPush & ~push_ok;
        unf_d    = iPop & ~pop_ok;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (push_ok) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (pop_ok && !push_ok && count_q == CW'(1))
                    state_d = ST_EMPTY;
                else if (push_ok && !pop_ok && count_q == DEPTH_C - CW'(1))
                    state_d = ST_FULL;
            end
            ST_FULL: begin
                if (pop_ok && !push_ok) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Clock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= pop_ok;
            // Flags are decoded from next-state values so they line up with oCount.
            full_q   <= (state_d == ST_FULL);
            empty_q  <= (state_d == ST_EMPTY);
            afull_q  <= (count_d >= AF_C);
            aempty_q <= (count_d <= AE_C);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign oDataOut     = data_q;
    assign oDataValid   = valid_q;
    assign oFull        = full_q;
    assign oEmpty       = empty_q;
    assign oAlmostFull  = afull_q;
    assign oAlmostEmpty = aempty_q;
    assign oCount       = count_q;
    assign oOverflow    = ovf_q;
    assign oUnderflow   = unf_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl with a behavioural 8x6 RAM (combinational read, clocked write).
module tb_fifo_mem_ctrl;

    logic       Clock = 1'b0;
    logic       iReset_n;
    logic       iPush, iPop;
    logic [5:0] iDataIn;
    logic [5:0] oDataOut;
    logic       oDataValid, oFull, oEmpty, oAlmostFull, oAlmostEmpty;
    logic [3:0] oCount;
    logic       oOverflow, oUnderflow;
    logic       oMemWriteEnable, oMemReadEnable;
    logic [2:0] oMemWriteAddress, oMemReadAddress;
    logic [5:0] oMemDataIn, iMemDataOut;

    logic [5:0] mem [8];
    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] q[$];
    logic [5:0] exp_d;

    always #5 Clock = ~Clock;

    always @(posedge Clock) if (oMemWriteEnable) mem[oMemWriteAddress] <= oMemDataIn;
    assign iMemDataOut = mem[oMemReadAddress];

    fifo_mem_ctrl dut (
        .Clock(Clock), .iReset_n(iReset_n),
        .iPush(iPush), .iDataIn(iDataIn), .iPop(iPop),
        .oDataOut(oDataOut), .oDataValid(oDataValid),
        .oFull(oFull), .oEmpty(oEmpty),
        .oAlmostFull(oAlmostFull), .oAlmostEmpty(oAlmostEmpty),
        .oCount(oCount), .oOverflow(oOverflow), .oUnderflow(oUnderflow),
        .oMemWriteEnable(oMemWriteEnable), .oMemWriteAddress(oMemWriteAddress),
        .oMemDataIn(oMemDataIn), .oMemReadEnable(oMemReadEnable),
        .oMemReadAddress(oMemReadAddress), .iMemDataOut(iMemDataOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic push, input logic [5:0] din, input logic pop);
        iPush = push; iDataIn = din; iPop = pop;
    endtask

    initial begin
        iReset_n = 1'b0;
        drive(1'b0, 6'h00, 1'b0);
        tick(); tick();
        chk("rst_count", oCount, 0);
        chk("rst_empty", oEmpty, 1);
        chk("rst_aempty", oAlmostEmpty, 1);
        chk("rst_full", oFull, 0);
        chk("rst_afull", oAlmostFull, 0);
        chk("rst_dout", oDataOut, 0);
        chk("rst_valid", oDataValid, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_unf", oUnderflow, 0);
        iReset_n = 1'b1;
        tick();

        // Fill with 1..8
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 6'(i + 1), 1'b0);
            #1;
            chk("fill_waddr", oMemWriteAddress, i);
            chk("fill_we", oMemWriteEnable, 1);
            tick();
            chk("fill_count", oCount, i + 1);
            chk("fill_afull", oAlmostFull, (i + 1 >= 6) ? 1 : 0);
            chk("fill_full", oFull, (i + 1 == 8) ? 1 : 0);
        end

        // Overflow: push while full, no pop
        drive(1'b1, 6'h3F, 1'b0);
        #1;
        chk("ovf_we", oMemWriteEnable, 0);
        tick();
        chk("ovf_flag", oOverflow, 1);
        chk("ovf_count", oCount, 8);
        drive(1'b0, 6'h00, 1'b0);
        tick();
`ifdef FIFO_STICKY_ERR_EN
        chk("ovf_hold", oOverflow, 1);
`else
        chk("ovf_pulse_end", oOverflow, 0);
`endif

        // Full with push+pop: oldest word out, 0x2A written to the same slot
        drive(1'b1, 6'h2A, 1'b1);
        #1;
        chk("fpp_raddr", oMemReadAddress, 0);
        chk("fpp_waddr", oMemWriteAddress, 0);
        chk("fpp_we", oMemWriteEnable, 1);
        tick();
        chk("fpp_valid", oDataValid, 1);
        chk("fpp_dout", oDataOut, 6'h01);
        chk("fpp_count", oCount, 8);
        chk("fpp_full", oFull, 1);

        // Drain: 2..8 then 0x2A
        for (int i = 0; i < 8; i++) begin
            exp_d = (i == 7) ? 6'h2A : 6'(i + 2);
            drive(1'b0, 6'h00, 1'b1);
            tick();
            chk("drain_valid", oDataValid, 1);
            chk("drain_dout", oDataOut, exp_d);
            chk("drain_count", oCount, 7 - i);
            chk("drain_aempty", oAlmostEmpty, (7 - i <= 2) ? 1 : 0);
        end
        chk("drain_empty", oEmpty, 1);
        drive(1'b0, 6'h00, 1'b0);
        tick();
        chk("idle_valid", oDataValid, 0);
        chk("idle_dout_hold", oDataOut, 6'h2A);

        // Underflow: pop alone on empty
        drive(1'b0, 6'h00, 1'b1);
        #1;
        chk("unf_re", oMemReadEnable, 0);
        tick();
        chk("unf_flag", oUnderflow, 1);
        chk("unf_valid", oDataValid, 0);

        // Empty with push+pop: push only
        drive(1'b1, 6'h15, 1'b1);
        tick();
        chk("epp_count", oCount, 1);
        chk("epp_unf", oUnderflow, 1);
        chk("epp_valid", oDataValid, 0);
        drive(1'b0, 6'h00, 1'b1);
        tick();
        chk("epp_pop_dout", oDataOut, 6'h15);
        chk("epp_pop_valid", oDataValid, 1);
        chk("epp_pop_count", oCount, 0);
`ifdef FIFO_STICKY_ERR_EN
        chk("unf_hold", oUnderflow, 1);
`else
        chk("unf_pulse_end", oUnderflow, 0);
`endif

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 6'(8'h20 + i), (i >= 2));
            if (i >= 2) exp_d = q.pop_front();
            q.push_back(6'(8'h20 + i));
            tick();
            if (i >= 2) begin
                chk("wrap_valid", oDataValid, 1);
                chk("wrap_dout", oDataOut, exp_d);
            end
        end
        chk("wrap_count", oCount, 2);

        // Asynchronous reset mid-stream
        drive(1'b1, 6'h33, 1'b1);
        #2;
        iReset_n = 1'b0;
        #1;
        chk("mrst_count", oCount, 0);
        chk("mrst_empty", oEmpty, 1);
        chk("mrst_dout", oDataOut, 0);
        chk("mrst_valid", oDataValid, 0);
        tick();
        drive(1'b0, 6'h00, 1'b0);
        iReset_n = 1'b1;
        tick();
        chk("post_rst_count", oCount, 0);
        chk("post_rst_empty", oEmpty, 1);
        chk("post_rst_ovf", oOverflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
- Pointer and flag controller that drives both ports of the team's dual-port RAM (8 x 6-bit by default), turning it into a synchronous FIFO.
- Client side: push/pop handshake. Memory side: write enable/address/data, read enable/address, and combinational read-data return.
- Sits between a producer/consumer pair and one RAM instance.
- The RAM read port is combinational, so popped data is captured in this block and presented registered.

Parameters:
- DATA_WIDTH, 6: word width; must match the RAM.
- ADDR_WIDTH, 3: pointer width; depth = 2**ADDR_WIDTH (8), matching a RAM built with MEM_SIZE = 7.
- ALMOST_FULL, 6: oAlmostFull asserts when count >= this value.
- ALMOST_EMPTY, 2: oAlmostEmpty asserts when count <= this value.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iPush  in  1  push request.
- iDataIn  in  DATA_WIDTH  push data.
- iPop  in  1  pop request.
- oDataOut  out  DATA_WIDTH  registered pop data.
- oDataValid  out  1  oDataOut valid; 1-cycle pulse per accepted pop.
- oFull  out  1  count == depth.
- oEmpty  out  1  count == 0.
- oAlmostFull  out  1  see ALMOST_FULL.
- oAlmostEmpty  out  1  see ALMOST_EMPTY.
- oCount  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- oOverflow  out  1  rejected-push indicator.
- oUnderflow  out  1  rejected-pop indicator.
- oMemWriteEnable  out  1  to RAM iWriteEnable.
- oMemWriteAddress  out  ADDR_WIDTH  to RAM iWriteAddress; equals wr_ptr.
- oMemDataIn  out  DATA_WIDTH  to RAM iDataIn; equals iDataIn.
- oMemReadEnable  out  1  to RAM iReadEnable.
- oMemReadAddress  out  ADDR_WIDTH  to RAM iReadAddress; equals rd_ptr.
- iMemDataOut  in  DATA_WIDTH  from RAM oDataOut.

Behaviour:
- Reset (async assert, synchronous release)
  - wr_ptr = rd_ptr = 0, count = 0, state = EMPTY.
  - oDataOut = 0, oDataValid = 0, oOverflow = 0, oUnderflow = 0.
  - oEmpty = 1, oAlmostEmpty = 1, oFull = 0, oAlmostFull = 0.
  - Reset mid-operation discards all contents. RAM contents are not cleared but are unreachable.
- Accept rules (combinational)
  - push_ok = iPush & (!oFull | pop_ok).
  - pop_ok = iPop & !oEmpty.
  - oMemWriteEnable = push_ok; oMemReadEnable = pop_ok. Both are combinational, no latency.
- Pop latency
  - On a pop_ok cycle, iMemDataOut (RAM word at rd_ptr) is registered into oDataOut at the edge, and oDataValid = 1 the following cycle.
  - oDataOut holds its value when no pop occurs.
- Pointer and count update on edge
  - wr_ptr += push_ok; rd_ptr += pop_ok; both wrap naturally modulo depth (7 -> 0).
  - count += push_ok - pop_ok, computed in ADDR_WIDTH+1 bits.
- FSM states: EMPTY, PARTIAL, FULL. All flags are registered decodes of state/count.
  - EMPTY -> PARTIAL on push_ok.
  - PARTIAL -> EMPTY when count == 1 and pop-only.
  - PARTIAL -> FULL when count == depth-1 and push-only.
  - FULL -> PARTIAL on pop-only.
  - Simultaneous push+pop holds the current state.
- Boundary: full with push+pop
  - Both accepted; write and read target the same address.
  - The read returns the old word (combinational read before the edge), then the new word is written.
  - Count stays at depth.
- Boundary: empty with push+pop
  - Push accepted, pop rejected (no bypass), underflow raised.
  - Count becomes 1.
- Overflow: push while full without pop drops the word, no pointer change, oOverflow = 1 for one cycle (the cycle after).
- Underflow: pop while empty: oUnderflow = 1 for one cycle, oDataValid stays 0.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined: oOverflow and oUnderflow, once set, stay 1 until iReset_n is asserted. FIFO operation is otherwise unchanged.
- Undefined: both are single-cycle pulses as described above.

Test Plan:
- Reset, then 8 pushes of 0x01..0x08 -> oCount steps 1..8; oAlmostFull from count 6; oFull = 1 after the 8th; oMemWriteAddress 0..7.
- 8 pops after the fill -> oDataOut 0x01..0x08, each with oDataValid one cycle after iPop; oEmpty = 1 at the end; oAlmostEmpty from count 2.
- Full, push 0x3F with no pop -> oOverflow pulse (sticky under macro), oCount = 8, the next 8 pops still return the original data.
- Full, push 0x2A + pop same cycle -> popped data = oldest word; oCount = 8; 0x2A is later read last.
- Empty, pop alone -> oUnderflow = 1, oDataValid = 0. Empty, push 0x15 + pop -> oCount = 1, oUnderflow = 1, the next pop returns 0x15.
- 20 pushes/pops interleaved across the pointer wrap, then iReset_n low mid-stream -> data order preserved across 7 -> 0; after reset oCount = 0, oEmpty = 1, oDataOut = 0.
